// File: rtl/counter_4b_monitor.sv
// Monitor for one 4-bit counter. It runs a cycle-accurate model of the counter,
// compares the counter's registered outputs every cycle and keeps error statistics.
module counter_4b_monitor #(
  parameter int ERR_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_enable,
  input  logic [1:0]       mon_mode,
  input  logic [3:0]       mon_D,
  input  logic [3:0]       mon_Q,
  input  logic             mon_load,
  input  logic             mon_rco,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] chk_count,
  output logic [5:0]       first_exp,
  output logic [5:0]       first_obs,
  output logic             fail
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_expQ;
  logic             r_expLoad;
  logic             r_expRco;
  logic             r_errPulse;
  logic [ERR_W-1:0] r_errCount;
  logic [ERR_W-1:0] r_chkCount;
  logic [5:0]       r_firstExp;
  logic [5:0]       r_firstObs;
  logic             r_fail;

  logic [3:0] w_nextQ;
  logic       w_nextLoad;
  logic       w_nextRco;
  logic [4:0] w_sumUp3;
  logic [5:0] w_expVec;
  logic [5:0] w_obsVec;
  logic       w_mismatch;
  logic       w_errMax;
  logic       w_chkMax;

  // Next model state follows the counter's own rules from the sampled stimulus.
  always_comb begin
    w_sumUp3   = {1'b0, r_expQ} + 5'd3;
    w_nextQ    = r_expQ;
    w_nextLoad = 1'b0;
    w_nextRco  = 1'b0;
    if (mon_enable) begin
      case (mon_mode)
        2'b00: begin
          w_nextQ   = r_expQ + 4'd1;
          w_nextRco = (r_expQ == 4'hF);
        end
        2'b01: begin
          w_nextQ   = r_expQ - 4'd1;
          w_nextRco = (r_expQ == 4'h0);
        end
        2'b10: begin
          w_nextQ   = w_sumUp3[3:0];
          w_nextRco = w_sumUp3[4];
        end
        default: begin
          w_nextQ    = mon_D;
          w_nextLoad = 1'b1;
        end
      endcase
    end
  end

  // Case-inequality so that X/Z on the observed outputs is flagged as a mismatch.
  assign w_expVec   = {r_expLoad, r_expRco, r_expQ};
  assign w_obsVec   = {mon_load, mon_rco, mon_Q};
  assign w_mismatch = (w_obsVec !== w_expVec);
  assign w_errMax   = (r_errCount == {ERR_W{1'b1}});
  assign w_chkMax   = (r_chkCount == {ERR_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_expQ     <= 4'd0;
      r_expLoad  <= 1'b0;
      r_expRco   <= 1'b0;
      r_errPulse <= 1'b0;
      r_errCount <= '0;
      r_chkCount <= '0;
      r_firstExp <= 6'd0;
      r_firstObs <= 6'd0;
      r_fail     <= 1'b0;
    end else begin
      r_errPulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_expQ    <= w_nextQ;
          r_expLoad <= w_nextLoad;
          r_expRco  <= w_nextRco;
          r_state   <= TRACK;
        end
        TRACK: begin
          if (!w_chkMax) r_chkCount <= r_chkCount + ERR_W'(1);
          if (w_mismatch) begin
            r_errPulse <= 1'b1;
            if (!w_errMax) r_errCount <= r_errCount + ERR_W'(1);
            // Only the first failing sample is kept for debug.
            if (!r_fail) begin
              r_firstExp <= w_expVec;
              r_firstObs <= w_obsVec;
              r_fail     <= 1'b1;
              if (STOP_ON_ERR) r_state <= HALT;
            end
          end
          r_expQ    <= w_nextQ;
          r_expLoad <= w_nextLoad;
          r_expRco  <= w_nextRco;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign err_pulse = r_errPulse;
  assign err_count = r_errCount;
  assign chk_count = r_chkCount;
  assign first_exp = r_firstExp;
  assign first_obs = r_firstObs;
  assign fail      = r_fail;

endmodule
